// File: rtl/sensor_trace_ctrl_if.sv
// Trace readout stream toward the CPA host: valid/ready with a last-sample marker.
interface sensor_trace_ctrl_if #(
   parameter int CODE_W = 7
);
   logic [CODE_W-1:0] rd_data;
   logic              rd_valid;
   logic              rd_ready;
   logic              rd_last;

   modport master (output rd_data, rd_valid, rd_last, input rd_ready);
   modport slave  (input rd_data, rd_valid, rd_last, output rd_ready);
endinterface

// File: rtl/sensor_trace_ctrl.sv
// Acquisition sequencer for the delay-line power sensor: trigger, delay, decimated
// capture into a trace buffer, then streamed readout.
module sensor_trace_ctrl #(
   parameter int CODE_W = 7,
   parameter int ADDR_W = 8,
   parameter int DLY_W  = 16,
   parameter int DEC_W  = 4
) (
   input  logic                clkin,
   input  logic                rstin,
   input  logic                arm,
   input  logic                abort,
   input  logic                trig_in,
   input  logic [DLY_W-1:0]    cfg_delay,
   input  logic [ADDR_W:0]     cfg_len,
   input  logic [DEC_W-1:0]    cfg_decim,
   input  logic [CODE_W-1:0]   codedin,
   sensor_trace_ctrl_if.master rd,
   output logic                busy,
   output logic                done,
   output logic                trig_miss
);
   localparam int              DEPTH   = 1 << ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

   typedef enum logic [2:0] {IDLE, ARMED, DELAY, CAPTURE, READOUT} state_t;

   state_t             state_q, state_d;
   logic               trig_d_q;
   logic [DLY_W-1:0]   dly_q, dly_d, cdly_q, cdly_d;
   logic [DEC_W-1:0]   dec_q, dec_d, cdec_q, cdec_d;
   logic [ADDR_W:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, len_q, len_d;
   logic               done_q, done_d, miss_q, miss_d;
   logic               wr_en, trig_edge, last;
   logic [ADDR_W:0]    wr_nxt, len_clamp;
   logic [CODE_W-1:0]  mem [DEPTH];

   assign trig_edge = trig_in & ~trig_d_q;
   assign wr_nxt    = wr_ptr_q + 1'b1;
   // Zero or oversize lengths both mean a full buffer.
   assign len_clamp = (cfg_len == '0 || cfg_len > DEPTH_L) ? DEPTH_L : cfg_len;
   assign last      = (state_q == READOUT) && (rd_ptr_q == len_q - 1'b1);

   always_comb begin
      state_d  = state_q;
      dly_d    = dly_q;
      dec_d    = dec_q;
      cdly_d   = cdly_q;
      cdec_d   = cdec_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      len_d    = len_q;
      done_d   = 1'b0;
      miss_d   = miss_q;
      wr_en    = 1'b0;
      if (trig_edge && state_q != ARMED) miss_d = 1'b1;
      case (state_q)
         IDLE: if (arm) begin
            cdly_d  = cfg_delay;
            cdec_d  = cfg_decim;
            len_d   = len_clamp;
            miss_d  = 1'b0;
            state_d = ARMED;
         end
         ARMED: if (trig_edge) begin
            dly_d   = cdly_q;
            state_d = DELAY;
         end
         DELAY: if (dly_q == '0) begin
            dec_d    = '0;
            wr_ptr_d = '0;
            state_d  = CAPTURE;
         end else begin
            dly_d = dly_q - 1'b1;
         end
         CAPTURE: if (dec_q == '0) begin
            wr_en    = 1'b1;
            dec_d    = cdec_q;
            wr_ptr_d = wr_nxt;
            if (wr_nxt == len_q) begin
               rd_ptr_d = '0;
               state_d  = READOUT;
            end
         end else begin
            dec_d = dec_q - 1'b1;
         end
         READOUT: if (rd.rd_ready) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            if (last) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // Abort wins over everything and must not disturb the miss flag.
      if (abort) begin
         state_d = IDLE;
         done_d  = 1'b0;
         miss_d  = miss_q;
         wr_en   = 1'b0;
      end
   end

   always_ff @(posedge clkin or posedge rstin) begin
      if (rstin) begin
         state_q  <= IDLE;
         trig_d_q <= 1'b0;
         dly_q    <= '0;
         dec_q    <= '0;
         cdly_q   <= '0;
         cdec_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         len_q    <= '0;
         done_q   <= 1'b0;
         miss_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         trig_d_q <= trig_in;
         dly_q    <= dly_d;
         dec_q    <= dec_d;
         cdly_q   <= cdly_d;
         cdec_q   <= cdec_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         len_q    <= len_d;
         done_q   <= done_d;
         miss_q   <= miss_d;
      end
   end

   always_ff @(posedge clkin) begin
      if (wr_en) mem[wr_ptr_q[ADDR_W-1:0]] <= codedin;
   end

   assign rd.rd_valid = (state_q == READOUT);
   assign rd.rd_last  = last;
   assign rd.rd_data  = (state_q == READOUT) ? mem[rd_ptr_q[ADDR_W-1:0]] : '0;
   assign busy        = (state_q != IDLE);
   assign done        = done_q;
   assign trig_miss   = miss_q;
endmodule
